// File: rtl/mem_copy_engine.sv
// Block copy / constant fill initiator for a 256x8 synchronous single-port memory.
// Optional running checksum of written bytes when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] xfer_count,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            state;
  logic              mode_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] fill_r;
  logic              abort_pend;

  logic [ADDR_W-1:0] idx_nxt;
  logic              last_byte;
  logic              stop_req;

  assign idx_nxt   = idx + ADDR_W'(1);
  assign last_byte = (idx_nxt == len_r);
  assign stop_req  = abort | abort_pend;

  // Copy data comes straight from the memory's registered output, which is
  // held stable for the whole WR cycle because write_en is high.
  always_comb begin
    mem_wdata = '0;
    if (state == WR)
      mem_wdata = mode_r ? fill_r : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_r       <= 1'b0;
      src_r        <= '0;
      dst_r        <= '0;
      len_r        <= '0;
      idx          <= '0;
      fill_r       <= '0;
      abort_pend   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      xfer_count   <= '0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done         <= 1'b0;
          aborted      <= 1'b0;
          mem_write_en <= 1'b0;
          mem_addr     <= '0;
          if (start) begin
            mode_r     <= mode;
            src_r      <= src_addr;
            dst_r      <= dst_addr;
            len_r      <= length;
            fill_r     <= fill_val;
            idx        <= '0;
            xfer_count <= '0;
            abort_pend <= 1'b0;
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode) begin
              state        <= WR;
              busy         <= 1'b1;
              mem_write_en <= 1'b1;
              mem_addr     <= dst_addr;
            end else begin
              state    <= RD;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end
        RD: begin
          // An abort seen while reading lets the current byte finish first.
          abort_pend   <= abort;
          state        <= WR;
          mem_write_en <= 1'b1;
          mem_addr     <= dst_r + idx;
        end
        WR: begin
          idx        <= idx_nxt;
          xfer_count <= xfer_count + ADDR_W'(1);
          if (last_byte || stop_req) begin
            state        <= FIN;
            busy         <= 1'b0;
            done         <= 1'b1;
            aborted      <= ~last_byte;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
          end else if (mode_r) begin
            mem_addr <= dst_r + idx_nxt;
          end else begin
            state        <= RD;
            mem_write_en <= 1'b0;
            mem_addr     <= src_r + idx_nxt;
          end
        end
        FIN: begin
          state   <= IDLE;
          done    <= 1'b0;
          aborted <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum_r <= '0;
    else if (state == IDLE && start)
      sum_r <= '0;
    else if (state == WR)
      sum_r <= sum_r + mem_wdata;
  end

  assign checksum = sum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a behavioural 256x8 registered-read memory.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] length = '0;
  logic [7:0] fill_val = '0;
  logic       abort = 1'b0;
  logic       busy, done, aborted;
  logic [7:0] xfer_count, checksum;
  logic       mem_write_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .xfer_count(xfer_count), .checksum(checksum),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: write when write_en, otherwise register the read; data_out held during writes.
  logic [7:0] mem [256];
  logic       mem_clr = 1'b1;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write_en) begin
      mem[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       ab;
    logic [7:0] xfer;
    logic [7:0] sum;
    int         lat;
  } done_t;

  logic [15:0] wq [$];
  done_t       dq [$];
  int          checks = 0;
  int          fails = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  logic [7:0]  cur_sum = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en) begin
        if (wq.size() == 0) begin
          check("unexpected_write_addr", int'(mem_addr), -1);
        end else begin
          logic [15:0] w;
          w = wq.pop_front();
          check("write_addr", int'(mem_addr), int'(w[15:8]));
          check("write_data", int'(mem_wdata), int'(w[7:0]));
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = dq.pop_front();
          check("done_aborted", int'(aborted), int'(d.ab));
          check("done_xfer_count", int'(xfer_count), int'(d.xfer));
          check("done_checksum", int'(checksum), int'(d.sum));
          check("done_latency", cyc - start_cyc, d.lat);
          check("done_busy_low", int'(busy), 0);
        end
      end
    end
  end

  task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
    wq.push_back({a, d});
    cur_sum = cur_sum + d;
  endtask

  task automatic exp_done(input logic ab, input logic [7:0] xfer, input int lat);
    done_t d;
    d.ab = ab;
    d.xfer = xfer;
`ifdef MEM_COPY_CHECKSUM_EN
    d.sum = cur_sum;
`else
    d.sum = 8'h00;
`endif
    d.lat = lat;
    dq.push_back(d);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the start strobe.
  task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] dst,
                       input logic [7:0] len, input logic [7:0] fv);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = dst; length = len; fill_val = fv;
    start = 1'b1;
    start_cyc = cyc;
    cur_sum = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
      #1;
    end
    if (done_cnt == d0) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic chk_mem(input string name, input logic [7:0] a, input logic [7:0] exp);
    check(name, int'(mem[a]), int'(exp));
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_aborted"}, int'(aborted), 0);
    check({tag, "_xfer_count"}, int'(xfer_count), 0);
    check({tag, "_checksum"}, int'(checksum), 0);
    check({tag, "_mem_write_en"}, int'(mem_write_en), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Copy 4 bytes 0x10 -> 0x80
    preload(8'h10, 8'h11); preload(8'h11, 8'h22);
    preload(8'h12, 8'h33); preload(8'h13, 8'h44);
    preload(8'h01, 8'h77);
    exp_write(8'h80, 8'h11); exp_write(8'h81, 8'h22);
    exp_write(8'h82, 8'h33); exp_write(8'h83, 8'h44);
    exp_done(1'b0, 8'd4, 9);
    issue(1'b0, 8'h10, 8'h80, 8'd4, 8'h00);
    check("copy_busy", int'(busy), 1);
    wait_done("copy", 40);
    chk_mem("copy_mem80", 8'h80, 8'h11);
    chk_mem("copy_mem83", 8'h83, 8'h44);

    // Fill with address wrap
    exp_write(8'hFE, 8'h5A); exp_write(8'hFF, 8'h5A); exp_write(8'h00, 8'h5A);
    exp_done(1'b0, 8'd3, 4);
    issue(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A);
    wait_done("fill_wrap", 40);
    chk_mem("fill_memFF", 8'hFF, 8'h5A);
    chk_mem("fill_mem00", 8'h00, 8'h5A);
    chk_mem("fill_mem01_untouched", 8'h01, 8'h77);

    // Zero length
    exp_done(1'b0, 8'd0, 1);
    issue(1'b0, 8'h10, 8'h90, 8'd0, 8'h00);
    wait_done("zero_len", 20);

    // Abort during the 3rd read of a 10-byte copy
    for (int i = 0; i < 10; i++) preload(8'h50 + 8'(i), 8'h01 + 8'(i));
    exp_write(8'hA0, 8'h01); exp_write(8'hA1, 8'h02); exp_write(8'hA2, 8'h03);
    exp_done(1'b1, 8'd3, 7);
    issue(1'b0, 8'h50, 8'hA0, 8'd10, 8'h00);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 40);
    chk_mem("abort_memA3_untouched", 8'hA3, 8'h00);

    // Start while busy is ignored
    exp_write(8'h40, 8'h11); exp_write(8'h41, 8'h22);
    exp_write(8'h42, 8'h33); exp_write(8'h43, 8'h44);
    exp_done(1'b0, 8'd4, 9);
    issue(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
    repeat (2) @(negedge clk);
    mode = 1'b1; src_addr = 8'h60; dst_addr = 8'hC0; length = 8'd7; fill_val = 8'hEE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy", 40);
    chk_mem("start_busy_memC0_untouched", 8'hC0, 8'h00);

    // Reset in the middle of a fill
    exp_write(8'h20, 8'hC3); exp_write(8'h21, 8'hC3);
    issue(1'b1, 8'h00, 8'h20, 8'd8, 8'hC3);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    chk_mem("midrst_mem21", 8'h21, 8'hC3);
    chk_mem("midrst_mem22_untouched", 8'h22, 8'h00);

    // Normal operation after reset
    exp_write(8'h30, 8'h99); exp_write(8'h31, 8'h99);
    exp_done(1'b0, 8'd2, 3);
    issue(1'b1, 8'h00, 8'h30, 8'd2, 8'h99);
    wait_done("post_rst_fill", 20);
    repeat (3) @(negedge clk);

    check("write_queue_drained", wq.size(), 0);
    check("done_queue_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
